acc_reg_bank: RTL and testbench
===============================

// Module: acc_reg_bank
// PURPOSE
//  Parametrised successor to the single 8-bit accumulator register (load IA,
//  bus enable EA). Holds NREG registers of WIDTH bits, one selected by SEL.
//  Adds in-place ALU-style ops with Z/C flags and an LSB-first serial shift-out
//  engine. Sits on the model computer's data bus as the accumulator/working file.
// PARAMETERS
//  WIDTH  8  data width of each register, bus and shifter (>=2)
//  NREG   4  number of registers (power of 2, >=2); SELW = clog2(NREG)
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RST        in   1      asynchronous reset, active-high
//  IA         in   1      load enable: reg[SEL] <= DinA
//  EA         in   1      bus output enable for Dout
//  OP         in   3      in-place operation on reg[SEL] (ignored when IA=1)
//  SEL        in   SELW   register select for load, op, read, serial capture
//  DinA       in   WIDTH  load data
//  SER_START  in   1      start serial shift-out of reg[SEL]
//  QA         out  WIDTH  reg[SEL], combinational read, always driven
//  Dout       out  WIDTH  EA ? reg[SEL] : 0
//  Z          out  1      registered zero flag of last written result
//  C          out  1      registered carry/borrow/shifted-out bit
//  SER_OUT    out  1      serial data bit, LSB first
//  BUSY       out  1      high while in SHIFT state
//  DONE       out  1      one-cycle pulse after last serial bit
// BEHAVIOUR
//  - RST high (any time, async): all regs=0, Z=1, C=0, FSM=IDLE, shift reg=0,
//    bit counter=0, SER_OUT=0, BUSY=0, DONE=0. QA/Dout then read 0.
//  - Write priority per edge: IA load > OP. Load: Z=(DinA==0), C unchanged.
//  - OP (IA=0), result R into reg[SEL], Z=(R==0), 1-cycle latency:
//    000 hold (no flag change) | 001 clear R=0,C=0 | 010 inc, C=carry-out
//    011 dec, C=borrow (1 on 0->all-ones) | 100 shl, C=old MSB, LSB=0
//    101 shr, C=old LSB, MSB=0 | 110 rotl, C=old MSB | 111 not, C unchanged
//  - Arithmetic mod 2^WIDTH: inc of all-ones -> 0,C=1,Z=1; dec of 0 -> all-ones.
//  - Only reg[SEL] changes; other registers hold.
//  - Serial FSM: IDLE -> SHIFT on SER_START (captures reg[SEL] into shift reg,
//    counter=0). SHIFT: SER_OUT=shreg[0]; each edge shreg>>=1, counter++;
//    after WIDTH bits -> DONE. DONE: DONE=1 for one cycle, -> IDLE.
//  - First serial bit visible the cycle after the SER_START edge; BUSY high
//    exactly WIDTH cycles; SER_OUT=0 outside SHIFT.
//  - SER_START while BUSY or DONE ignored. Bank writes during SHIFT allowed and
//    do not affect the captured word. SER_START with IA same edge captures the
//    pre-load value.
//  - RST mid-shift aborts: BUSY=0, no DONE pulse.
// TESTING (WIDTH=8, NREG=4)
//  - Reset: RST=1 mid-run -> QA=Dout=0, Z=1, C=0, BUSY=0 immediately (async).
//  - Load/enable: IA=1,SEL=2,DinA=8'hFB -> QA=8'hFB; EA=0 Dout=0, EA=1 Dout=8'hFB;
//    SEL=1 -> QA=0 (other regs untouched).
//  - Inc wrap: load 8'hFF, OP=010 -> reg=8'h00, C=1, Z=1; OP=011 -> 8'hFF, C=1, Z=0.
//  - Shifts: load 8'h81, OP=100 -> 8'h02 C=1; OP=101 -> 8'h01 C=0; OP=110 on 8'h81
//    -> 8'h03 C=1; IA=1 with OP=001 same edge -> DinA wins.
//  - Serial: reg=8'h0B, SER_START -> SER_OUT 1,1,0,1,0,0,0,0 over 8 cycles, BUSY=8
//    cycles, DONE 1 pulse; second SER_START during SHIFT ignored.
//  - Abort: RST at 4th serial bit -> BUSY=0, SER_OUT=0, no DONE; next start works.

Source files
------------

// File: rtl/acc_reg_bank.sv
// acc_reg_bank: bank of NREG accumulator registers of WIDTH bits with in-place
// ALU-style ops, Z/C flags and an LSB-first serial shift-out engine.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   ia         in   load enable: reg[sel] <= dina (wins over op)
//   ea         in   bus enable for dout
//   op         in   in-place operation on reg[sel] when ia=0
//   sel        in   register select (load, op, read, serial capture)
//   dina       in   load data
//   ser_start  in   start serial shift-out of reg[sel] (ignored unless idle)
//   qa         out  reg[sel], combinational read
//   dout       out  ea ? reg[sel] : 0, combinational
//   z, c       out  registered zero / carry flags of last written result
//   ser_out    out  serial data bit, LSB first, 0 outside the shift phase
//   busy       out  high for exactly WIDTH cycles while shifting
//   done       out  one-cycle pulse after the last serial bit
module acc_reg_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ia,
    input  logic                     ea,
    input  logic [2:0]               op,
    input  logic [$clog2(NREG)-1:0]  sel,
    input  logic [WIDTH-1:0]         dina,
    input  logic                     ser_start,
    output logic [WIDTH-1:0]         qa,
    output logic [WIDTH-1:0]         dout,
    output logic                     z,
    output logic                     c,
    output logic                     ser_out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_CLR  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             wr;
    logic             z_d;
    logic             c_d;
    op_e              op_q;

    state_e           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CNTW-1:0]  cnt, cnt_d;
    logic             busy_d;
    logic             done_d;

    // Combinational read ports
    assign cur  = regs[sel];
    assign qa   = cur;
    assign dout = ea ? cur : '0;
    assign op_q = op_e'(op);

    // Result and flag computation for the selected register; load beats op
    always_comb begin
        res = cur;
        sum = '0;
        wr  = 1'b0;
        z_d = z;
        c_d = c;
        if (ia) begin
            res = dina;
            wr  = 1'b1;
        end else begin
            case (op_q)
                OP_HOLD: wr = 1'b0;
                OP_CLR: begin
                    res = '0;
                    c_d = 1'b0;
                    wr  = 1'b1;
                end
                OP_INC: begin
                    sum = {1'b0, cur} + (WIDTH+1)'(1);
                    res = sum[WIDTH-1:0];
                    c_d = sum[WIDTH];
                    wr  = 1'b1;
                end
                OP_DEC: begin
                    res = cur - WIDTH'(1);
                    c_d = (cur == '0);
                    wr  = 1'b1;
                end
                OP_SHL: begin
                    res = {cur[WIDTH-2:0], 1'b0};
                    c_d = cur[WIDTH-1];
                    wr  = 1'b1;
                end
                OP_SHR: begin
                    res = {1'b0, cur[WIDTH-1:1]};
                    c_d = cur[0];
                    wr  = 1'b1;
                end
                OP_ROL: begin
                    res = {cur[WIDTH-2:0], cur[WIDTH-1]};
                    c_d = cur[WIDTH-1];
                    wr  = 1'b1;
                end
                OP_NOT: begin
                    res = ~cur;
                    wr  = 1'b1;
                end
                default: wr = 1'b0;
            endcase
        end
        if (wr) begin
            z_d = (res == '0);
        end
    end

    // Register bank and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            z <= 1'b1;
            c <= 1'b0;
        end else begin
            if (wr) begin
                regs[sel] <= res;
            end
            z <= z_d;
            c <= c_d;
        end
    end

    // Serial engine next-state; shreg is cleared outside SHIFT so bit 0 is the output
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ser_start) begin
                    state_d = S_SHIFT;
                    shreg_d = cur;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt + CNTW'(1);
                if (cnt == CNTW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    shreg_d = '0;
                    done_d  = 1'b1;
                end else begin
                    shreg_d = shreg >> 1;
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Serial engine state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    assign ser_out = shreg[0];

endmodule

// File: tb/tb_acc_reg_bank.sv
// Directed bench for acc_reg_bank (WIDTH=8, NREG=4): expectations are queued as
// stimulus is applied and popped when the DUT output is sampled.
module tb_acc_reg_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREG  = 4;

    logic             clk;
    logic             rst;
    logic             ia;
    logic             ea;
    logic [2:0]       op;
    logic [1:0]       sel;
    logic [WIDTH-1:0] dina;
    logic             ser_start;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] dout;
    logic             z;
    logic             c;
    logic             ser_out;
    logic             busy;
    logic             done;

    acc_reg_bank #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .ia        (ia),
        .ea        (ea),
        .op        (op),
        .sel       (sel),
        .dina      (dina),
        .ser_start (ser_start),
        .qa        (qa),
        .dout      (dout),
        .z         (z),
        .c         (c),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] val;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;

    task automatic push(input string tag, input logic [WIDTH-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [WIDTH-1:0] obs);
        exp_t e;
        n_total++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=<none queued>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] s, input logic [WIDTH-1:0] d);
        sel  = s;
        dina = d;
        ia   = 1'b1;
        tick();
        ia   = 1'b0;
    endtask

    task automatic op_step(input logic [1:0] s, input logic [2:0] o,
                           input logic [WIDTH-1:0] eq, input logic ec, input logic ez);
        sel = s;
        op  = o;
        push($sformatf("op%0d_q", o), eq);
        push($sformatf("op%0d_c", o), WIDTH'(ec));
        push($sformatf("op%0d_z", o), WIDTH'(ez));
        tick();
        op = 3'b000;
        pop_chk(qa);
        pop_chk(WIDTH'(c));
        pop_chk(WIDTH'(z));
    endtask

    initial begin
        logic [WIDTH-1:0] w;

        rst = 1'b0; ia = 1'b0; ea = 1'b1; op = 3'b000; sel = 2'd0;
        dina = '0; ser_start = 1'b0;

        // Asynchronous reset, observed before any clock edge
        #1 rst = 1'b1;
        push("rst_qa", 8'h00); push("rst_dout", 8'h00); push("rst_z", 8'h01);
        push("rst_c", 8'h00); push("rst_busy", 8'h00); push("rst_ser", 8'h00);
        push("rst_done", 8'h00);
        #1;
        pop_chk(qa); pop_chk(dout); pop_chk(WIDTH'(z)); pop_chk(WIDTH'(c));
        pop_chk(WIDTH'(busy)); pop_chk(WIDTH'(ser_out)); pop_chk(WIDTH'(done));
        tick();
        rst = 1'b0;
        tick();

        // Load and bus enable
        ea = 1'b0;
        push("ld_qa", 8'hFB); push("ld_dout_off", 8'h00); push("ld_z", 8'h00);
        load(2'd2, 8'hFB);
        pop_chk(qa); pop_chk(dout); pop_chk(WIDTH'(z));
        ea = 1'b1;
        push("ld_dout_on", 8'hFB);
        #1 pop_chk(dout);
        sel = 2'd1;
        push("other_qa", 8'h00); push("other_dout", 8'h00);
        #1 pop_chk(qa); pop_chk(dout);

        // Increment wrap and decrement borrow
        load(2'd2, 8'hFF);
        op_step(2'd2, 3'b010, 8'h00, 1'b1, 1'b1);
        op_step(2'd2, 3'b011, 8'hFF, 1'b1, 1'b0);

        // Shifts, rotate, not, hold, clear
        load(2'd2, 8'h81);
        op_step(2'd2, 3'b100, 8'h02, 1'b1, 1'b0);
        op_step(2'd2, 3'b101, 8'h01, 1'b0, 1'b0);
        load(2'd2, 8'h81);
        op_step(2'd2, 3'b110, 8'h03, 1'b1, 1'b0);
        op_step(2'd2, 3'b111, 8'hFC, 1'b1, 1'b0);
        op_step(2'd2, 3'b000, 8'hFC, 1'b1, 1'b0);
        op_step(2'd2, 3'b001, 8'h00, 1'b0, 1'b1);
        load(2'd2, 8'h80);
        op_step(2'd2, 3'b100, 8'h00, 1'b1, 1'b1);

        // Load beats clear on the same edge; carry untouched by load
        push("pri_qa", 8'h5A); push("pri_c", 8'h01); push("pri_z", 8'h00);
        sel = 2'd2; dina = 8'h5A; ia = 1'b1; op = 3'b001;
        tick();
        ia = 1'b0; op = 3'b000;
        pop_chk(qa); pop_chk(WIDTH'(c)); pop_chk(WIDTH'(z));
        sel = 2'd0;
        push("r0_qa", 8'h00);
        #1 pop_chk(qa);

        // Serial shift-out with an ignored restart and a bank write mid-shift
        load(2'd3, 8'h0B);
        w = 8'h0B;
        sel = 2'd3; ser_start = 1'b1;
        tick();
        ser_start = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            push($sformatf("ser_bit%0d", i), WIDTH'(w[i]));
            push("ser_busy", 8'h01); push("ser_done", 8'h00);
            pop_chk(WIDTH'(ser_out)); pop_chk(WIDTH'(busy)); pop_chk(WIDTH'(done));
            if (i == 2) ser_start = 1'b1;
            if (i == 3) begin
                ia = 1'b1; dina = 8'h00;
            end
            tick();
            ser_start = 1'b0;
            ia = 1'b0;
        end
        push("end_done", 8'h01); push("end_busy", 8'h00); push("end_ser", 8'h00);
        pop_chk(WIDTH'(done)); pop_chk(WIDTH'(busy)); pop_chk(WIDTH'(ser_out));
        tick();
        push("post_done", 8'h00); push("post_busy", 8'h00); push("midwr_qa", 8'h00);
        pop_chk(WIDTH'(done)); pop_chk(WIDTH'(busy)); pop_chk(qa);

        // Start with a same-edge load captures the old value; reset aborts at bit 4
        load(2'd3, 8'hA5);
        w = 8'hA5;
        sel = 2'd3; dina = 8'h00; ia = 1'b1; ser_start = 1'b1;
        tick();
        ia = 1'b0; ser_start = 1'b0;
        push("cap_qa", 8'h00);
        pop_chk(qa);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("ab_bit%0d", i), WIDTH'(w[i])); push("ab_busy", 8'h01);
            pop_chk(WIDTH'(ser_out)); pop_chk(WIDTH'(busy));
            if (i < 3) tick();
        end
        #2 rst = 1'b1;
        push("ab_busy_rst", 8'h00); push("ab_ser_rst", 8'h00); push("ab_qa_rst", 8'h00);
        push("ab_z_rst", 8'h01); push("ab_c_rst", 8'h00);
        #1;
        pop_chk(WIDTH'(busy)); pop_chk(WIDTH'(ser_out)); pop_chk(qa);
        pop_chk(WIDTH'(z)); pop_chk(WIDTH'(c));
        rst = 1'b0;
        for (int k = 0; k < int'(WIDTH) + 1; k++) begin
            tick();
            push("ab_nodone", 8'h00); push("ab_idle_busy", 8'h00);
            pop_chk(WIDTH'(done)); pop_chk(WIDTH'(busy));
        end

        // Fresh start after the abort
        load(2'd0, 8'h06);
        w = 8'h06;
        sel = 2'd0; ser_start = 1'b1;
        tick();
        ser_start = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            push($sformatf("rs_bit%0d", i), WIDTH'(w[i])); push("rs_busy", 8'h01);
            pop_chk(WIDTH'(ser_out)); pop_chk(WIDTH'(busy));
            tick();
        end
        push("rs_done", 8'h01); push("rs_busy_end", 8'h00);
        pop_chk(WIDTH'(done)); pop_chk(WIDTH'(busy));
        tick();
        push("rs_done_off", 8'h00);
        pop_chk(WIDTH'(done));

        if (sbq.size() != 0) begin
            n_total++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
